// File: rtl/qr_pkg.sv
// ---------------------------------------------------------------------------
// qr_pkg
// Shared definitions for the QR_CORDIC row sequencer.
//   - state_e       : sequencer FSM states (LOAD / ISSUE / WAIT / DRAIN)
//   - QR_DATA_WIDTH : default bits per signed matrix element
//   - QR_D_WIDTH    : default elements per row (array width)
//   - QR_ROWS       : default rows per matrix
//   - QR_ROW_W      : default packed row width in bits
// ---------------------------------------------------------------------------
package qr_pkg;

    localparam int QR_DATA_WIDTH = 20;
    localparam int QR_D_WIDTH    = 4;
    localparam int QR_ROWS       = 8;
    localparam int QR_ROW_W      = QR_DATA_WIDTH * QR_D_WIDTH;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

endpackage : qr_pkg

// File: rtl/qr_row_buf.sv
// ---------------------------------------------------------------------------
// qr_row_buf
// DEPTH-deep row register file with one synchronous write port and one
// combinational read port. Contents are not reset; every row is written
// before it is read within a matrix pass.
// Ports:
//   i_clk      : clock (rising edge)
//   i_wr_en    : write strobe
//   i_wr_addr  : write row index
//   i_wr_data  : write row data
//   i_rd_addr  : read row index
//   o_rd_data  : read row data (combinational)
// ---------------------------------------------------------------------------
module qr_row_buf
    import qr_pkg::*;
#(
    parameter int ROW_W = QR_ROW_W,
    parameter int DEPTH = QR_ROWS,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [ROW_W-1:0] i_wr_data,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [ROW_W-1:0] o_rd_data
);

    logic [ROW_W-1:0] r_mem [DEPTH];

    // Row storage write port.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : qr_row_buf

// File: rtl/qr_cordic_sched.sv
// ---------------------------------------------------------------------------
// qr_cordic_sched
// Buffers one ROWS x D_WIDTH matrix from a host (valid/ready), issues it to
// the QR_CORDIC array as one gap-free burst (the array has no backpressure),
// captures ROWS result rows and returns them to a consumer (valid/ready).
// Optional watchdog: define QR_SCHED_TIMEOUT_EN to abort a WAIT that sees no
// result progress for TIMEOUT cycles (err pulses, FSM returns to LOAD).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : host row handshake, in_row = host row (elem 0 MSBs)
//   core_valid_i/a_ij    : registered burst to the array
//   core_valid_o/out_r   : result rows from the array
//   out_valid/out_ready  : consumer handshake; out_row/out_idx/out_last
//   busy                 : high in ISSUE or WAIT
//   err                  : one-cycle watchdog pulse (0 without the macro)
// ---------------------------------------------------------------------------
module qr_cordic_sched
    import qr_pkg::*;
#(
    parameter int DATA_WIDTH = QR_DATA_WIDTH,
    parameter int D_WIDTH    = QR_D_WIDTH,
    parameter int ROWS       = QR_ROWS,
    parameter int TIMEOUT    = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*D_WIDTH-1:0] in_row,
    output logic                          core_valid_i,
    output logic [DATA_WIDTH*D_WIDTH-1:0] core_a_ij,
    input  logic                          core_valid_o,
    input  logic [DATA_WIDTH*D_WIDTH-1:0] core_out_r,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH*D_WIDTH-1:0] out_row,
    output logic [$clog2(ROWS)-1:0]       out_idx,
    output logic                          out_last,
    output logic                          busy,
    output logic                          err
);

    localparam int ROW_W = DATA_WIDTH * D_WIDTH;
    localparam int AW    = $clog2(ROWS);
    localparam int CW    = $clog2(ROWS + 1);
    localparam logic [CW-1:0] C_LAST = CW'(ROWS - 1);
    localparam logic [CW-1:0] C_FULL = CW'(ROWS);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CW-1:0]    r_wcnt;
    logic [CW-1:0]    r_icnt;
    logic [CW-1:0]    r_ccnt;
    logic [CW-1:0]    r_rcnt;
    logic             r_core_valid_i;
    logic [ROW_W-1:0] r_core_a_ij;
    logic             w_in_acc;
    logic             w_last_acc;
    logic             w_out_acc;
    logic             w_cap;
    logic             w_tmo;
    logic [ROW_W-1:0] w_ibuf_rd;
    logic [ROW_W-1:0] w_obuf_rd;

    assign in_ready   = rst_n && (r_state == LOAD);
    assign w_in_acc   = in_valid && in_ready;
    assign w_last_acc = w_in_acc && (r_wcnt == C_LAST);
    // Capture only while a matrix is in flight and not yet complete.
    assign w_cap      = ((r_state == ISSUE) || (r_state == WAIT)) &&
                        core_valid_o && (r_ccnt != C_FULL);
    assign w_out_acc  = out_valid && out_ready;

    qr_row_buf #(.ROW_W(ROW_W), .DEPTH(ROWS), .AW(AW)) u_ibuf (
        .i_clk     (clk),
        .i_wr_en   (w_in_acc),
        .i_wr_addr (r_wcnt[AW-1:0]),
        .i_wr_data (in_row),
        .i_rd_addr (r_icnt[AW-1:0]),
        .o_rd_data (w_ibuf_rd)
    );

    qr_row_buf #(.ROW_W(ROW_W), .DEPTH(ROWS), .AW(AW)) u_obuf (
        .i_clk     (clk),
        .i_wr_en   (w_cap),
        .i_wr_addr (r_ccnt[AW-1:0]),
        .i_wr_data (core_out_r),
        .i_rd_addr (r_rcnt[AW-1:0]),
        .o_rd_data (w_obuf_rd)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD: begin
                if (w_last_acc) w_state_nxt = ISSUE;
                else            w_state_nxt = LOAD;
            end
            ISSUE: begin
                if (r_icnt == C_FULL) w_state_nxt = WAIT;
                else                  w_state_nxt = ISSUE;
            end
            WAIT: begin
                if (r_ccnt == C_FULL) w_state_nxt = DRAIN;
                else if (w_tmo)       w_state_nxt = LOAD;
                else                  w_state_nxt = WAIT;
            end
            DRAIN: begin
                if (w_out_acc && (r_rcnt == C_LAST)) w_state_nxt = LOAD;
                else                                 w_state_nxt = DRAIN;
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Row counters: host write, burst issue, result capture, consumer read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wcnt <= CW'(0);
            r_icnt <= CW'(0);
            r_ccnt <= CW'(0);
            r_rcnt <= CW'(0);
        end else begin
            if (w_last_acc)    r_wcnt <= CW'(0);
            else if (w_in_acc) r_wcnt <= r_wcnt + CW'(1);
            else               r_wcnt <= r_wcnt;

            // r_icnt is the ibuf row presented on the next edge; row 0 goes
            // out on the edge of the final accept, so issuing starts at 1.
            if (w_last_acc)                                r_icnt <= CW'(1);
            else if (r_state == ISSUE && r_icnt != C_FULL) r_icnt <= r_icnt + CW'(1);
            else if (r_state == ISSUE)                     r_icnt <= CW'(0);
            else                                           r_icnt <= r_icnt;

            if (w_state_nxt == LOAD) r_ccnt <= CW'(0);
            else if (w_cap)          r_ccnt <= r_ccnt + CW'(1);
            else                     r_ccnt <= r_ccnt;

            if (w_state_nxt == LOAD) r_rcnt <= CW'(0);
            else if (w_out_acc)      r_rcnt <= r_rcnt + CW'(1);
            else                     r_rcnt <= r_rcnt;
        end
    end

    // Registered burst to the array; first row launches with the final accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_core_valid_i <= 1'b0;
            r_core_a_ij    <= ROW_W'(0);
        end else if (w_last_acc || (r_state == ISSUE && r_icnt != C_FULL)) begin
            r_core_valid_i <= 1'b1;
            r_core_a_ij    <= w_ibuf_rd;
        end else begin
            r_core_valid_i <= 1'b0;
            r_core_a_ij    <= ROW_W'(0);
        end
    end

`ifdef QR_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);

    logic [WW-1:0] r_wdog;
    logic          r_err;

    // Stalled-WAIT detection: no capture on the final allowed cycle.
    assign w_tmo = (r_state == WAIT) && !w_cap && (r_ccnt != C_FULL) &&
                   (r_wdog == WW'(TIMEOUT - 1));

    // Watchdog counts WAIT cycles without a capture; cleared outside WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wdog <= WW'(0);
            r_err  <= 1'b0;
        end else begin
            r_err <= w_tmo;
            if (r_state != WAIT)  r_wdog <= WW'(0);
            else if (!w_cap)      r_wdog <= r_wdog + WW'(1);
            else                  r_wdog <= r_wdog;
        end
    end

    assign err = r_err;
`else
    logic w_unused_tmo;

    assign w_tmo        = 1'b0;
    assign err          = 1'b0;
    assign w_unused_tmo = (TIMEOUT > 0);
`endif

    assign core_valid_i = r_core_valid_i;
    assign core_a_ij    = r_core_a_ij;
    assign busy         = (r_state == ISSUE) || (r_state == WAIT);
    assign out_valid    = (r_state == DRAIN);
    assign out_row      = out_valid ? w_obuf_rd : ROW_W'(0);
    assign out_idx      = out_valid ? r_rcnt[AW-1:0] : AW'(0);
    assign out_last     = out_valid && (r_rcnt == C_LAST);

endmodule : qr_cordic_sched

// File: tb/tb_qr_cordic_sched.sv
// ---------------------------------------------------------------------------
// tb_qr_cordic_sched
// Scoreboard bench for qr_cordic_sched. Accepted host rows are queued as the
// expected burst and as the expected results (the core model echoes rows
// after a configurable latency). Watchdog scenario runs when
// QR_SCHED_TIMEOUT_EN is defined (TIMEOUT=16).
// ---------------------------------------------------------------------------
module tb_qr_cordic_sched;

    localparam int DW = 20;
    localparam int NW = 4;
    localparam int R  = 8;
    localparam int RW = DW * NW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [RW-1:0] in_row;
    logic          core_valid_i;
    logic [RW-1:0] core_a_ij;
    logic          core_valid_o;
    logic [RW-1:0] core_out_r;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic [2:0]    out_idx;
    logic          out_last;
    logic          busy;
    logic          err;

    qr_cordic_sched #(.DATA_WIDTH(DW), .D_WIDTH(NW), .ROWS(R), .TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .core_valid_i (core_valid_i),
        .core_a_ij    (core_a_ij),
        .core_valid_o (core_valid_o),
        .core_out_r   (core_out_r),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_row      (out_row),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [RW-1:0] make_row(input int v);
        return {DW'(v), DW'(v + 1), DW'(v + 2), DW'(v + 3)};
    endfunction

    // Core model: delay line echoing issued rows after lat cycles.
    logic [15:0]   cm_v = 16'h0000;
    logic [RW-1:0] cm_d [16];
    int            lat      = 5;
    bit            silent   = 1'b0;
    bit            extra_en = 1'b0;
    logic [RW-1:0] junk_row = {RW{1'b1}};

    // Core model pipeline.
    always @(posedge clk) begin
        cm_v    <= {cm_v[14:0], core_valid_i};
        cm_d[0] <= core_a_ij;
        for (int i = 1; i < 16; i++) cm_d[i] <= cm_d[i-1];
    end

    // Core model outputs; extra pulses follow the real rows when enabled.
    always @* begin
        core_valid_o = !silent && (cm_v[lat-1] || (extra_en && cm_v[lat+7]));
        core_out_r   = cm_v[lat-1] ? cm_d[lat-1] : junk_row;
    end

    // Scoreboard state.
    logic [RW-1:0] issue_q [$];
    logic [RW-1:0] exp_q   [$];
    int            acc_n        = 0;
    int            last_acc_cyc = 0;
    int            run_len      = 0;
    int            burst_cnt    = 0;
    int            burst_end    = 0;
    int            exp_idx      = 0;
    int            out_cnt      = 0;
    bit            prev_stall   = 1'b0;
    logic [RW-1:0] h_row;
    logic [2:0]    h_idx;
    logic          h_last;

    // Negedge monitor: accepts, burst shape/content, output handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (in_valid && in_ready) begin
                    issue_q.push_back(in_row);
                    exp_q.push_back(in_row);
                    acc_n++;
                    if (acc_n % R == 0) last_acc_cyc = cyc;
                end
                if (core_valid_i) begin
                    if (run_len == 0) check_eq("issue_start", cyc, last_acc_cyc + 1);
                    run_len++;
                    check_eq("issue_q_avail", issue_q.size() > 0, 1'b1);
                    if (issue_q.size() > 0) check_eq("issue_row", core_a_ij, issue_q.pop_front());
                end else if (run_len != 0) begin
                    check_eq("issue_len", run_len, R);
                    run_len   = 0;
                    burst_end = cyc;
                    burst_cnt++;
                end
                if (prev_stall) begin
                    check_eq("hold_valid", out_valid, 1'b1);
                    check_eq("hold_row", out_row, h_row);
                    check_eq("hold_idx", out_idx, h_idx);
                    check_eq("hold_last", out_last, h_last);
                end
                prev_stall = out_valid && !out_ready;
                h_row  = out_row;
                h_idx  = out_idx;
                h_last = out_last;
                if (out_valid && out_ready) begin
                    check_eq("out_q_avail", exp_q.size() > 0, 1'b1);
                    if (exp_q.size() > 0) check_eq("out_row", out_row, exp_q.pop_front());
                    check_eq("out_idx", out_idx, exp_idx);
                    check_eq("out_last", out_last, exp_idx == R - 1);
                    check_eq("in_ready_drain", in_ready, 1'b0);
                    exp_idx = (exp_idx + 1) % R;
                    out_cnt++;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic load_matrix(input int base, input bit gaps);
        int start = acc_n;
        int g     = 0;
        while (acc_n - start < R && g < 100) begin
            in_valid = gaps ? (g % 2 == 0) : 1'b1;
            in_row   = make_row(base + NW * (acc_n - start));
            @(posedge clk); #1;
            g++;
        end
        // Offer more rows: none may be accepted once the matrix is full.
        in_valid = 1'b1;
        in_row   = make_row(9999);
        repeat (2) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        check_eq("accept_count", acc_n - start, R);
    endtask

    task automatic drain(input int stall_idx, input int stall_n);
        int start = out_cnt;
        int g     = 0;
        int st    = 0;
        while (out_cnt - start < R && g < 300) begin
            if (out_valid && out_idx == stall_idx && st < stall_n) begin
                out_ready = 1'b0;
                st++;
            end else begin
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            g++;
        end
        check_eq("drain_count", out_cnt - start, R);
        check_eq("reentry_in_ready", in_ready, 1'b1);
        check_eq("reentry_out_valid", out_valid, 1'b0);
        check_eq("exp_q_empty", exp_q.size(), 0);
        if (stall_n > 0) check_eq("stall_cycles", st, stall_n);
        out_ready = 1'b0;
    endtask

    task automatic wait_burst();
        int b = burst_cnt;
        int g = 0;
        while (burst_cnt == b && g < 100) begin @(posedge clk); g++; end
        #1;
        check_eq("burst_seen", burst_cnt != b, 1'b1);
    endtask

    // Main sequence.
    initial begin
        int hi_cnt;
        int hi_cyc;
        int ov_cnt;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", in_ready, 1'b0);
        check_eq("rst_core_valid", core_valid_i, 1'b0);
        check_eq("rst_core_a", core_a_ij, '0);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_row", out_row, '0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", err, 1'b0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Basic flow: elements 1..32, echo after 5 cycles.
        lat = 5;
        load_matrix(1, 1'b0);
        drain(-1, 0);

        // Host gaps with a shorter core latency.
        lat = 3;
        load_matrix(101, 1'b1);
        drain(-1, 0);

        // Negative data and consumer backpressure at idx 2.
        lat = 7;
        load_matrix(-40, 1'b0);
        drain(2, 3);

        // Early output from the 6th ISSUE cycle plus trailing extra pulses.
        lat      = 5;
        extra_en = 1'b1;
        load_matrix(501, 1'b0);
        drain(-1, 0);
        repeat (10) @(posedge clk);
        #1;
        extra_en = 1'b0;

        // Mid-operation reset during WAIT with a silent core.
        silent = 1'b1;
        load_matrix(601, 1'b0);
        wait_burst();
`ifdef QR_SCHED_TIMEOUT_EN
        repeat (4) @(posedge clk);
`else
        repeat (40) @(posedge clk);
`endif
        #1;
        check_eq("wait_busy", busy, 1'b1);
        check_eq("wait_err", err, 1'b0);
        check_eq("wait_in_ready", in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_in_ready_low", in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check_eq("midrst_busy", busy, 1'b0);
        check_eq("midrst_core_valid", core_valid_i, 1'b0);
        check_eq("midrst_out_valid", out_valid, 1'b0);
        check_eq("midrst_in_ready", in_ready, 1'b1);
        check_eq("midrst_err", err, 1'b0);
        issue_q.delete();
        exp_q.delete();
        exp_idx = 0;

`ifdef QR_SCHED_TIMEOUT_EN
        // Watchdog: silent core, err one cycle 16 cycles after WAIT entry.
        load_matrix(801, 1'b0);
        wait_burst();
        hi_cnt = 0;
        hi_cyc = 0;
        ov_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (err) begin hi_cnt++; hi_cyc = cyc; end
            if (out_valid) ov_cnt++;
        end
        check_eq("tmo_err_pulses", hi_cnt, 1);
        check_eq("tmo_err_cycle", hi_cyc, burst_end + 16);
        check_eq("tmo_no_drain", ov_cnt, 0);
        check_eq("tmo_in_ready", in_ready, 1'b1);
        check_eq("tmo_busy", busy, 1'b0);
        issue_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
`else
        hi_cnt = 0;
        hi_cyc = 0;
        ov_cnt = 0;
`endif

        // Recovery after reset/abort.
        silent = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        lat = 4;
        load_matrix(701, 1'b0);
        drain(1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global run limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "run limit reached");
    end

endmodule : tb_qr_cordic_sched
